// File: rtl/ab_pattern_gen.sv
// ============================================================================
// ab_pattern_gen
// ----------------------------------------------------------------------------
// Purpose:
//   Stimulus driver for the two-input sticky-AND detector. It plays the fixed
//   a/b sequence 11 -> 01 -> 10 -> 00. Each step is held for a programmable
//   number of clock cycles (dwell). The whole four-step sequence is repeated a
//   programmable number of times (reps). A start/busy/done handshake lets a
//   controller launch a run and wait for it to complete.
//
// Ports:
//   clk    in   1        system clock, rising-edge active
//   rst    in   1        asynchronous, active-high reset
//   start  in   1        one-cycle run request, sampled only while idle
//   dwell  in   DWELL_W  cycles per step (0 behaves as 1), latched on start
//   reps   in   REP_W    full sequences per run (0 behaves as 1), latched on start
//   a      out  1        stimulus bit a (registered)
//   b      out  1        stimulus bit b (registered)
//   step   out  2        current step index: 0=11, 1=01, 2=10, 3=00
//   busy   out  1        high for the whole run (4 * dwell * reps cycles)
//   done   out  1        single-cycle pulse in the cycle after the run ends
// ============================================================================
`timescale 1ns/1ps

module ab_pattern_gen #(
    parameter int DWELL_W = 8,
    parameter int REP_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [REP_W-1:0]   reps,
    output logic               a,
    output logic               b,
    output logic [1:0]         step,
    output logic               busy,
    output logic               done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] LAST_STEP = 2'd3;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_e             state_q,     state_d;
    logic [1:0]         step_q,      step_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [REP_W-1:0]   rep_cnt_q,   rep_cnt_d;
    logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
    logic [REP_W-1:0]   reps_lat_q,  reps_lat_d;
    logic               a_q,         a_d;
    logic               b_q,         b_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;

    // ------------------------------------------------------------------------
    // Effective run parameters: a programmed zero behaves as one, so a step
    // is always held at least one cycle and a run always has one sequence.
    // ------------------------------------------------------------------------
    logic [DWELL_W-1:0] eff_dwell;
    logic [REP_W-1:0]   eff_reps;
    logic               dwell_last;
    logic               rep_last;

    assign eff_dwell  = (dwell_lat_q == '0) ? DWELL_W'(1) : dwell_lat_q;
    assign eff_reps   = (reps_lat_q  == '0) ? REP_W'(1)   : reps_lat_q;

    // eff_* >= 1, so subtracting one never wraps and the counters never need
    // to count past the latched value: no overflow is possible.
    assign dwell_last = (dwell_cnt_q == eff_dwell - DWELL_W'(1));
    assign rep_last   = (rep_cnt_q   == eff_reps  - REP_W'(1));

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    // NOTE: every signal written here is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        dwell_cnt_d = dwell_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        dwell_lat_d = dwell_lat_q;
        reps_lat_d  = reps_lat_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    // Capture the run parameters now; later changes on the
                    // dwell/reps inputs cannot disturb a run in progress.
                    dwell_lat_d = dwell;
                    reps_lat_d  = reps;
                    state_d     = ST_RUN;
                    step_d      = 2'd0;
                    dwell_cnt_d = '0;
                    rep_cnt_d   = '0;
                    busy_d      = 1'b1;
                end
            end

            ST_RUN: begin
                // start is deliberately not examined here: requests while
                // busy are dropped, not queued.
                if (dwell_last) begin
                    dwell_cnt_d = '0;
                    if (step_q == LAST_STEP) begin
                        if (rep_last) begin
                            // Final dwell of the final sequence: leave RUN
                            // so busy covers exactly 4*dwell*reps cycles.
                            state_d = ST_DONE;
                            step_d  = 2'd0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_W'(1);
                            step_d    = 2'd0;
                        end
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
            end

            ST_DONE: begin
                // One-cycle completion state; done_d defaults low so the
                // pulse ends on the way back to IDLE.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                step_d  = 2'd0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                step_d  = 2'd0;
            end
        endcase
    end

    // a/b are decoded from the *next* step so that the registered outputs line
    // up with the registered step index. Outside RUN both bits are forced low.
    always_comb begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (state_d == ST_RUN) begin
            unique case (step_d)
                2'd0:    begin a_d = 1'b1; b_d = 1'b1; end
                2'd1:    begin a_d = 1'b0; b_d = 1'b1; end
                2'd2:    begin a_d = 1'b1; b_d = 1'b0; end
                default: begin a_d = 1'b0; b_d = 1'b0; end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= 2'd0;
            dwell_cnt_q <= '0;
            rep_cnt_q   <= '0;
            dwell_lat_q <= '0;
            reps_lat_q  <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            dwell_cnt_q <= dwell_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            dwell_lat_q <= dwell_lat_d;
            reps_lat_q  <= reps_lat_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: straight from registers, no combinational paths from inputs.
    // ------------------------------------------------------------------------
    assign a    = a_q;
    assign b    = b_q;
    assign step = step_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ab_pattern_gen.sv
// ============================================================================
// tb_ab_pattern_gen
// ----------------------------------------------------------------------------
// Self-checking bench for ab_pattern_gen. A reference model describes a run as
// "cycle k of a run of length 4*D*R": the expected step is (k / D) % 4, the
// a/b pair comes from a lookup table, and the cycle after the run is the done
// cycle. Every clock the DUT outputs are compared with that model.
// ============================================================================
`timescale 1ns/1ps

module tb_ab_pattern_gen;

    localparam int DWELL_W = 8;
    localparam int REP_W   = 4;

    logic               clk;
    logic               rst;
    logic               start;
    logic [DWELL_W-1:0] dwell;
    logic [REP_W-1:0]   reps;
    logic               a;
    logic               b;
    logic [1:0]         step;
    logic               busy;
    logic               done;

    ab_pattern_gen #(
        .DWELL_W (DWELL_W),
        .REP_W   (REP_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dwell (dwell),
        .reps  (reps),
        .a     (a),
        .b     (b),
        .step  (step),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;   // busy-high cycles seen since the last launch
    int done_cnt = 0;   // done pulses seen since the last launch

    // ------------------------------------------------------------------------
    // Reference model: mode 0 = idle, 1 = running, 2 = done cycle.
    // ------------------------------------------------------------------------
    int m_mode = 0;
    int m_k    = 0;
    int m_d    = 1;
    int m_r    = 1;
    logic [1:0] ab_table [4] = '{2'b11, 2'b01, 2'b10, 2'b00};

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [1:0] e_step;
        logic [1:0] e_ab;
        logic       e_busy;
        logic       e_done;
        e_step = 2'd0;
        e_ab   = 2'b00;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (m_mode == 1) begin
            e_step = 2'((m_k / m_d) % 4);
            e_ab   = ab_table[e_step];
            e_busy = 1'b1;
        end else if (m_mode == 2) begin
            e_done = 1'b1;
        end
        check("a",    32'(a),    32'(e_ab[1]));
        check("b",    32'(b),    32'(e_ab[0]));
        check("step", 32'(step), 32'(e_step));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
    endtask

    // One clock: advance the model with the inputs present at the edge, then
    // sample the DUT 1 ns later and compare.
    task automatic tick();
        @(posedge clk);
        case (m_mode)
            0: if (start) begin
                   m_mode = 1;
                   m_k    = 0;
                   m_d    = eff(int'(dwell));
                   m_r    = eff(int'(reps));
               end
            1: begin
                   m_k++;
                   if (m_k == 4 * m_d * m_r) m_mode = 2;
               end
            default: m_mode = 0;
        endcase
        #1;
        check_outputs();
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic launch(input int dw, input int rp);
        dwell    = DWELL_W'(dw);
        reps     = REP_W'(rp);
        start    = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        tick();
        start = 1'b0;
    endtask

    // Run the current job to completion (bounded) and check its length.
    task automatic finish_run(input string tag, input int exp_busy);
        int budget;
        budget = 3000;
        while (m_mode != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, "_timeout"}, 32'(budget > 0), 32'(1));
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(1));
    endtask

    task automatic wait_done_cycle(input string tag);
        int budget;
        budget = 3000;
        while (m_mode != 2 && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, "_timeout"}, 32'(budget > 0), 32'(1));
    endtask

    // Assert reset between clock edges and check it takes effect at once.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        m_mode = 0;
        check("rst_a",    32'(a),    32'(0));
        check("rst_b",    32'(b),    32'(0));
        check("rst_step", 32'(step), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Directed and randomized stimulus
    // ------------------------------------------------------------------------
    initial begin
        int dw;
        int rp;
        int gap;

        rst   = 1'b1;
        start = 1'b0;
        dwell = '0;
        reps  = '0;

        // 1. Reset state, then ten idle cycles.
        #1;
        check("reset_a",    32'(a),    32'(0));
        check("reset_b",    32'(b),    32'(0));
        check("reset_step", 32'(step), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) tick();

        // 2. dwell=3, reps=1: 12 busy cycles, one done pulse.
        launch(3, 1);
        check("t2_first_ab", 32'({a, b}), 32'(2'b11));
        finish_run("t2", 12);

        // 3. dwell=0, reps=0 behave as 1/1: 4 busy cycles.
        launch(0, 0);
        finish_run("t3", 4);

        // 4. dwell=2, reps=3 with an ignored start and changed inputs mid-run.
        launch(2, 3);
        repeat (5) tick();
        dwell = 8'd7;
        reps  = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_run("t4", 24);

        // 5. dwell=5, reps=2 interrupted by reset at cycle 13: no done pulse.
        launch(5, 2);
        repeat (11) tick();
        async_reset();
        check("t5_busy_before_rst", 32'(busy_cnt), 32'(12));
        repeat (3) tick();
        check("t5_no_done", 32'(done_cnt), 32'(0));
        launch(2, 1);
        check("t5_fresh_step", 32'(step), 32'(0));
        finish_run("t5", 8);

        // 6a. Start during the done cycle is ignored.
        launch(2, 1);
        wait_done_cycle("t6a");
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t6a_still_idle", 32'(busy), 32'(0));

        // 6b. Back-to-back: start in the cycle after done is accepted.
        launch(1, 1);
        wait_done_cycle("t6b");
        tick();
        launch(1, 1);
        check("t6b_second_ab", 32'({a, b}), 32'(2'b11));
        finish_run("t6b", 4);

        // Randomized runs with random mid-run input noise and stray starts.
        repeat (20) begin
            dw = int'($urandom_range(0, 6));
            rp = int'($urandom_range(0, 3));
            launch(dw, rp);
            while (m_mode != 0) begin
                dwell = DWELL_W'($urandom);
                reps  = REP_W'($urandom);
                start = ($urandom_range(0, 7) == 0);
                tick();
            end
            start = 1'b0;
            check("rand_busy_len", 32'(busy_cnt), 32'(4 * eff(dw) * eff(rp)));
            check("rand_done_cnt", 32'(done_cnt), 32'(1));
            gap = int'($urandom_range(0, 2));
            repeat (gap) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
